// File: rtl/sd_audio_decoder.sv
// Second-order CIC decimator recovering PCM from a 1-bit sigma-delta stream.
// Define SD_DEC_SIGNED_OUT_EN for two's-complement DOUT (offset binary otherwise).
module sd_audio_decoder #(
    parameter int DATA_W     = 16,
    parameter int DECIM_LOG2 = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CE,
    input  logic              DIN,
    output logic [DATA_W-1:0] DOUT,
    output logic              DOUT_VALID,
    output logic              SAT
);
    localparam int AW = 2*DECIM_LOG2 + 1;

`ifdef SD_DEC_SIGNED_OUT_EN
    localparam logic SIGNED_OUT = 1'b1;
`else
    localparam logic SIGNED_OUT = 1'b0;
`endif
    // Offset binary <-> two's complement is just the MSB; also the reset value.
    localparam logic [DATA_W-1:0] MSB_FLIP = {SIGNED_OUT, {(DATA_W-1){1'b0}}};

    logic [AW-1:0]         i1, i2, d1, d2, y, c1, c2;
    logic [DECIM_LOG2-1:0] cnt;
    logic [1:0]            warm;
    logic                  y_vld;
    logic                  tick;
    logic [DATA_W-1:0]     dout_n;

    assign tick   = CE && (cnt == '1);
    assign c1     = i2 - d1;
    assign c2     = c1 - d2;
    // Only the full-scale case R^2 reaches the top bit; clip it to all ones.
    assign dout_n = (y[AW-1] ? {DATA_W{1'b1}} : y[AW-2 -: DATA_W]) ^ MSB_FLIP;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            i1         <= '0;
            i2         <= '0;
            d1         <= '0;
            d2         <= '0;
            y          <= '0;
            cnt        <= '0;
            warm       <= 2'd0;
            y_vld      <= 1'b0;
            DOUT       <= MSB_FLIP;
            DOUT_VALID <= 1'b0;
            SAT        <= 1'b0;
        end else begin
            if (CE) begin
                i1  <= i1 + {{(AW-1){1'b0}}, DIN};
                i2  <= i2 + i1;
                cnt <= cnt + DECIM_LOG2'(1);
            end
            if (tick) begin
                d1 <= i2;
                d2 <= c1;
                y  <= c2;
                if (warm != 2'd2)
                    warm <= warm + 2'd1;
            end
            // Combs hold garbage until two ticks have primed D1/D2.
            y_vld      <= tick && (warm == 2'd2);
            DOUT_VALID <= y_vld;
            SAT        <= y_vld && y[AW-1];
            if (y_vld)
                DOUT <= dout_n;
        end
    end
endmodule

// File: tb/tb_sd_audio_decoder.sv
// Randomised bench for sd_audio_decoder: reference CIC model feeds a scoreboard
// queue; a monitor pops and compares on every DOUT_VALID.
module tb_sd_audio_decoder;
    localparam int DATA_W = 16;
    localparam int DL     = 8;
    localparam int R      = 1 << DL;
    localparam int AW     = 2*DL + 1;
    localparam int SH     = AW - 1 - DATA_W;
`ifdef SD_DEC_SIGNED_OUT_EN
    localparam logic [DATA_W-1:0] FLIP = 16'h8000;
`else
    localparam logic [DATA_W-1:0] FLIP = 16'h0000;
`endif

    logic              CLK = 1'b0;
    logic              RESET = 1'b1;
    logic              CE = 1'b0;
    logic              DIN = 1'b0;
    logic [DATA_W-1:0] DOUT;
    logic              DOUT_VALID;
    logic              SAT;

    sd_audio_decoder #(.DATA_W(DATA_W), .DECIM_LOG2(DL)) dut (
        .CLK(CLK), .RESET(RESET), .CE(CE), .DIN(DIN),
        .DOUT(DOUT), .DOUT_VALID(DOUT_VALID), .SAT(SAT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int                tick_cyc;
        logic [DATA_W-1:0] dout;
        logic              sat;
    } exp_t;
    exp_t sb[$];

    int checks = 0, passed = 0;
    int cyc = 0, vcount = 0;
    int ce_n, s1, acc, c1_prev, nticks;
    logic [DATA_W-1:0] last_dout = FLIP;
    int last_vld_cyc = -1;
    bit fixed_en = 0, spacing_en = 0, range_en = 0;
    logic [DATA_W-1:0] fixed_val;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Reference: C1 for tick k is the sum of the running ones-count over the
    // R CE samples preceding it; the output is the difference of consecutive C1.
    always @(posedge CLK) begin
        cyc++;
        if (RESET) begin
            ce_n = 0; s1 = 0; acc = 0; c1_prev = 0; nticks = 0;
            sb.delete();
            last_dout = FLIP;
            last_vld_cyc = -1;
        end else if (CE) begin
            if (ce_n % R == R-1) begin
                int c1, y;
                exp_t e;
                c1 = acc;
                y = c1 - c1_prev;
                c1_prev = c1;
                acc = s1;
                nticks++;
                if (nticks >= 3) begin
                    e.tick_cyc = cyc;
                    e.sat = (y >= R*R);
                    e.dout = (e.sat ? {DATA_W{1'b1}} : DATA_W'(y >> SH)) ^ FLIP;
                    sb.push_back(e);
                end
            end else begin
                acc += s1;
            end
            s1 += int'(DIN);
            ce_n++;
        end
    end

    always begin
        @(posedge CLK);
        #2;
        if (DOUT_VALID) begin
            vcount++;
            if (sb.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("latency_ok", (cyc - e.tick_cyc >= 1) && (cyc - e.tick_cyc <= 2), 1);
                chk("dout", DOUT, e.dout);
                chk("sat", SAT, e.sat);
                last_dout = e.dout;
            end
            if (fixed_en) chk("dout_fixed", DOUT, fixed_val);
            if (range_en) chk("loopback_in_range",
                              ((DOUT ^ FLIP) >= 16'h3FFE) && ((DOUT ^ FLIP) <= 16'h4002), 1);
            if (spacing_en && last_vld_cyc >= 0) chk("valid_spacing", cyc - last_vld_cyc, 2048);
            last_vld_cyc = cyc;
        end else begin
            chk("idle_hold", {DOUT, SAT}, {last_dout, 1'b0});
            if (sb.size() > 0 && cyc - sb[0].tick_cyc >= 2) begin
                chk("missing_valid", 0, 1);
                void'(sb.pop_front());
            end
        end
    end

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1; CE = 0; DIN = 0;
        #1;
        chk("reset_state", {DOUT, DOUT_VALID, SAT}, {FLIP, 2'b00});
        @(negedge CLK);
        RESET = 0;
    endtask

    // mode: 0 zeros, 1 ones, 2 alt 1/0, 3 1110, 4 first-order DAC @0x4000, 5 random density
    // ce_mode: 0 always, 1 every 8th CLK, 2 random
    task automatic run(input int nclk, input int mode, input int ce_mode);
        int pidx = 0;
        int dens = $urandom_range(0, 100);
        logic [15:0] dac = 16'h0;
        for (int i = 0; i < nclk; i++) begin
            logic ce, b;
            logic [16:0] sum;
            @(negedge CLK);
            ce = (ce_mode == 0) ? 1'b1 : (ce_mode == 1) ? (i % 8 == 7) : 1'($urandom_range(0, 1));
            sum = {1'b0, dac} + 17'h4000;
            case (mode)
                0: b = 1'b0;
                1: b = 1'b1;
                2: b = (pidx % 2 == 0);
                3: b = (pidx % 4 != 3);
                4: b = sum[16];
                default: b = ($urandom_range(0, 99) < dens);
            endcase
            if (ce) begin
                pidx++;
                dac = sum[15:0];
            end
            CE = ce;
            DIN = ce ? b : 1'($urandom_range(0, 1));
        end
    endtask

    task automatic phase(input int nclk, input int mode, input int ce_mode,
                         input bit fx, input logic [DATA_W-1:0] fv, input int min_v);
        int v0;
        do_reset();
        v0 = vcount;
        fixed_en = fx; fixed_val = fv;
        run(nclk, mode, ce_mode);
        @(negedge CLK); CE = 0;
        repeat (4) @(negedge CLK);
        fixed_en = 0;
        chk("drain_empty", sb.size(), 0);
        if (min_v > 0) chk("valid_count", vcount - v0, min_v);
    endtask

    initial begin
        int v0;
        phase(4*R, 0, 0, 1, 16'h0000 ^ FLIP, 2);
        phase(5*R, 1, 0, 1, 16'hFFFF ^ FLIP, 3);
        phase(5*R, 2, 0, 1, 16'h8000 ^ FLIP, 3);
        phase(5*R, 3, 0, 1, 16'hC000 ^ FLIP, 3);
        range_en = 1;
        phase(6*R, 4, 0, 0, '0, 4);
        range_en = 0;
        repeat (2) phase(12*R, 5, 2, 0, '0, 0);
        phase(5*R, 5, 0, 0, '0, 3);
        spacing_en = 1;
        phase(8*R*6, 3, 1, 1, 16'hC000 ^ FLIP, 4);
        spacing_en = 0;

        // Reset 50 CE into the frame after the first valid sample
        do_reset();
        run(3*R + 50, 1, 0);
        do_reset();
        v0 = vcount;
        run(3*R - 1, 1, 0);
        @(negedge CLK); CE = 0;
        repeat (3) @(negedge CLK);
        chk("no_valid_after_reset", vcount - v0, 0);
        run(1, 1, 0);
        @(negedge CLK); CE = 0;
        repeat (3) @(negedge CLK);
        chk("first_valid_after_reset", vcount - v0, 1);
        chk("drain_empty_end", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
